// File: rtl/sr_drv_pkg.sv
// Shared types and default parameters for the SR latch driver.
// State encoding plus PULSE_CYC / DEAD_CYC / CNT_W defaults.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    DEAD
  } sr_drv_state_t;

  localparam int SR_DRV_PULSE_CYC = 2;
  localparam int SR_DRV_DEAD_CYC  = 1;
  localparam int SR_DRV_CNT_W     = 8;

endpackage

// File: rtl/sr_drv_sync2.sv
// Two-flop synchronizer for the asynchronous latch Q feedback.
// Async active-low reset clears both stages to 0.
module sr_drv_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Request-to-pulse driver for the SR latch; S and R are never high together.
// Define SR_DRV_CHECK_EN to enable the synchronized q_fb checker (err).
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC = SR_DRV_PULSE_CYC,
  parameter int DEAD_CYC  = SR_DRV_DEAD_CYC,
  parameter int CNT_W     = SR_DRV_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_set,
  output logic s,
  output logic r,
  output logic busy,
  output logic state_exp,
  input  logic q_fb,
  output logic err
);

  if (PULSE_CYC < 1 || DEAD_CYC < 1) begin : g_bad_cyc
    $error("PULSE_CYC and DEAD_CYC must be >= 1");
  end
  if (PULSE_CYC >= 2**CNT_W || DEAD_CYC >= 2**CNT_W) begin : g_bad_w
    $error("PULSE_CYC/DEAD_CYC do not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] D_LD = CNT_W'(DEAD_CYC - 1);

  sr_drv_state_t    r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_s, w_s;
  logic             r_r, w_r;
  logic             r_exp, w_exp;
  logic             r_known, w_known;
  logic             r_live;
  logic             w_accept;
  logic             w_last_dead;

  assign req_ready   = r_live && (r_state == IDLE);
  assign w_accept    = req_valid && req_ready;
  assign w_last_dead = (r_state == DEAD) && (r_cnt == '0);

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_s     = r_s;
    w_r     = r_r;
    w_exp   = r_exp;
    w_known = r_known;
    case (r_state)
      IDLE: begin
        if (w_accept && !(r_known && (req_set == r_exp))) begin
          w_next  = PULSE;
          w_cnt   = P_LD;
          w_s     = req_set;
          w_r     = ~req_set;
          w_exp   = req_set;
          w_known = 1'b1;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_next = DEAD;
          w_cnt  = D_LD;
          w_s    = 1'b0;
          w_r    = 1'b0;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      DEAD: begin
        if (r_cnt == '0) begin
          w_next = IDLE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
        w_cnt  = '0;
        w_s    = 1'b0;
        w_r    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_exp   <= 1'b0;
      r_known <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_s     <= w_s;
      r_r     <= w_r;
      r_exp   <= w_exp;
      r_known <= w_known;
      r_live  <= 1'b1;
    end
  end

  assign s         = r_s;
  assign r         = r_r;
  assign busy      = (r_state != IDLE);
  assign state_exp = r_exp;

`ifdef SR_DRV_CHECK_EN
  logic w_q_sync;
  logic r_err;

  sr_drv_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (q_fb),
    .o_q   (w_q_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_last_dead && (w_q_sync != r_exp)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  // q_fb has no consumer when the checker is compiled out
  logic w_unused_q_fb;
  assign w_unused_q_fb = q_fb;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR latch model.
// Honours SR_DRV_CHECK_EN for the err expectations.
module tb_sr_latch_driver;

  logic clk;
  logic rst_n;
  logic req_valid;
  logic req_ready;
  logic req_set;
  logic s;
  logic r;
  logic busy;
  logic state_exp;
  logic q_fb;
  logic err;

  logic q_lat;
  logic tie0;
  int   n_chk;
  int   n_err;

`ifdef SR_DRV_CHECK_EN
  localparam logic ERR_T6 = 1'b1;
`else
  localparam logic ERR_T6 = 1'b0;
`endif

  sr_latch_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_set   (req_set),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .state_exp (state_exp),
    .q_fb      (q_fb),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial q_lat = 1'b0;
  always @(s or r) begin
    if (s) q_lat = 1'b1;
    else if (r) q_lat = 1'b0;
  end
  assign q_fb = tie0 ? 1'b0 : q_lat;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) chk("s_and_r", 32'(s & r), 32'd0);

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_set   = 1'b0;
    tie0      = 1'b0;

    // 1: reset holds everything low
    repeat (3) begin
      tick;
      req_valid = ~req_valid;
      req_set   = ~req_set;
      chk("rst_s", 32'(s), 0);
      chk("rst_r", 32'(r), 0);
      chk("rst_rdy", 32'(req_ready), 0);
      chk("rst_exp", 32'(state_exp), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("rdy_rel", 32'(req_ready), 0);
    tick;
    chk("rdy_up", 32'(req_ready), 1);

    // 2: set pulse with default timing
    req_valid = 1'b1;
    req_set   = 1'b1;
    tick;
    req_valid = 1'b0;
    chk("t2_s1", 32'(s), 1);
    chk("t2_r1", 32'(r), 0);
    chk("t2_rdy1", 32'(req_ready), 0);
    chk("t2_busy1", 32'(busy), 1);
    chk("t2_exp1", 32'(state_exp), 1);
    tick;
    chk("t2_s2", 32'(s), 1);
    tick;
    chk("t2_s3", 32'(s), 0);
    chk("t2_r3", 32'(r), 0);
    chk("t2_busy3", 32'(busy), 1);
    chk("t2_rdy3", 32'(req_ready), 0);
    tick;
    chk("t2_rdy4", 32'(req_ready), 1);
    chk("t2_busy4", 32'(busy), 0);
    chk("t2_exp4", 32'(state_exp), 1);
    chk("t2_err4", 32'(err), 0);

    // 3: redundant set dropped, then reset pulse; req_set ignored while busy
    req_valid = 1'b1;
    req_set   = 1'b1;
    tick;
    chk("t3_red_s", 32'(s), 0);
    chk("t3_red_rdy", 32'(req_ready), 1);
    chk("t3_red_busy", 32'(busy), 0);
    req_set = 1'b0;
    tick;
    req_set = 1'b1;
    chk("t3_r1", 32'(r), 1);
    chk("t3_s1", 32'(s), 0);
    chk("t3_exp1", 32'(state_exp), 0);
    tick;
    chk("t3_r2", 32'(r), 1);
    chk("t3_s2", 32'(s), 0);
    tick;
    chk("t3_r3", 32'(r), 0);
    chk("t3_rdy3", 32'(req_ready), 0);
    tick;
    chk("t3_rdy4", 32'(req_ready), 1);
    tick;
    req_valid = 1'b0;
    chk("t3_b2b_s", 32'(s), 1);
    chk("t3_b2b_exp", 32'(state_exp), 1);
    repeat (3) tick;
    chk("t3_rdy_end", 32'(req_ready), 1);
    chk("t3_err", 32'(err), 0);

    // 4: first request after reset always pulses
    rst_n = 1'b0;
    #1 chk("t4_exp_rst", 32'(state_exp), 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t4_rdy", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_set   = 1'b0;
    tick;
    req_valid = 1'b0;
    chk("t4_r1", 32'(r), 1);
    chk("t4_s1", 32'(s), 0);
    chk("t4_busy", 32'(busy), 1);
    repeat (3) tick;
    chk("t4_rdy_end", 32'(req_ready), 1);

    // 5: reset in the middle of a set pulse
    req_valid = 1'b1;
    req_set   = 1'b1;
    tick;
    req_valid = 1'b0;
    chk("t5_s_pre", 32'(s), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_s_async", 32'(s), 0);
    chk("t5_r_async", 32'(r), 0);
    chk("t5_busy_async", 32'(busy), 0);
    chk("t5_rdy_async", 32'(req_ready), 0);
    chk("t5_exp_async", 32'(state_exp), 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t5_rdy", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_set   = 1'b1;
    tick;
    req_valid = 1'b0;
    chk("t5_s1", 32'(s), 1);
    tick;
    chk("t5_s2", 32'(s), 1);
    tick;
    chk("t5_s3", 32'(s), 0);
    tick;
    chk("t5_rdy_end", 32'(req_ready), 1);

    // 6: feedback stuck low against a set pulse
    tie0  = 1'b1;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    req_valid = 1'b1;
    req_set   = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("t6_err_dead", 32'(err), 0);
    tick;
    chk("t6_err_set", 32'(err), 32'(ERR_T6));
    repeat (3) tick;
    chk("t6_err_sticky", 32'(err), 32'(ERR_T6));
    rst_n = 1'b0;
    #1 chk("t6_err_clr", 32'(err), 0);
    tick;
    rst_n = 1'b1;
    tie0  = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
